// File: rtl/snn_img_sequencer_pkg.sv
// Shared types and helpers for the SNN image sequencer: FSM state enum,
// index-width helper and default image/rest lengths.
// No ports; imported by the sequencer top, its interface users and spike_argmax.
package snn_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_TU = 3'd3,
        ST_REST    = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_e;

    localparam int unsigned SEQ_T_DEF    = 500;
    localparam int unsigned SEQ_HOLD_DEF = 50000;

    // Bits needed to index v items; never less than 1 so that single-item
    // indices still form a legal vector.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/snn_img_sequencer_if.sv
// Frame bus between input RAM / SNN core and the image sequencer.
// master = sequencer (drives frame_addr, ips, valid_board, nxt_img);
// slave  = RAM + core side (drives frame_data, TU_incre, ops).
interface snn_img_sequencer_if #(
    parameter int unsigned M  = 256,
    parameter int unsigned N  = 8,
    parameter int unsigned AW = 16
) ();
    logic [AW-1:0] frame_addr;
    logic [M-1:0]  frame_data;
    logic [M-1:0]  ips;
    logic          valid_board;
    logic          nxt_img;
    logic          TU_incre;
    logic [N-1:0]  ops;

    modport master (
        output frame_addr, ips, valid_board, nxt_img,
        input  frame_data, TU_incre, ops
    );

    modport slave (
        input  frame_addr, ips, valid_board, nxt_img,
        output frame_data, TU_incre, ops
    );
endinterface

// File: rtl/snn_img_sequencer_spike_argmax.sv
// Purpose: argmax over N spike counters of CW bits, lowest index wins ties.
// Latency: purely combinational.  Backpressure: none (no handshake).
// Ports: cnt_i (N packed counters), idx_o (index of the largest counter).
module spike_argmax
    import snn_seq_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 8
) (
    input  logic [N-1:0][CW-1:0] cnt_i,
    output logic [clog2(N)-1:0]  idx_o
);
    localparam int unsigned NW = clog2(N);

    logic [CW-1:0] best_val;

    // Strict '>' keeps the earliest index on equal counts; all-zero gives 0.
    always_comb begin
        idx_o    = '0;
        best_val = cnt_i[0];
        for (int i = 1; i < N; i++) begin
            if (cnt_i[i] > best_val) begin
                best_val = cnt_i[i];
                idx_o    = NW'(i);
            end
        end
    end
endmodule

// File: rtl/snn_img_sequencer.sv
// Purpose: streams NUM_IMG images of T RAM frames into the SNN core, rests HOLD cycles between images.
// Latency: start -> valid_board 2 cycles; TU_incre -> next valid_board 2 cycles (3-cycle min frame period).
// Backpressure: one frame in flight; the next frame waits for TU_incre from the core.
// Ports: clk, rst_n (async active-low), start, abort, bus (frame bus, master side),
//        busy, hold, done, img_idx, winner, winner_valid.
// Build option: SNN_SEQ_SPIKE_COUNT_EN adds per-neuron spike counters and winner reporting;
//               without it winner/winner_valid are tied to 0.
module snn_img_sequencer
    import snn_seq_pkg::*;
#(
    parameter int unsigned M       = 256,
    parameter int unsigned N       = 8,
    parameter int unsigned T       = SEQ_T_DEF,
    parameter int unsigned HOLD    = SEQ_HOLD_DEF,
    parameter int unsigned NUM_IMG = 2,
    parameter int unsigned AW      = 16,
    parameter int unsigned CW      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    snn_img_sequencer_if.master       bus,
    output logic                      busy,
    output logic                      hold,
    output logic                      done,
    output logic [clog2(NUM_IMG)-1:0] img_idx,
    output logic [clog2(N)-1:0]       winner,
    output logic                      winner_valid
);
    localparam int unsigned IW = clog2(NUM_IMG);
    localparam int unsigned NW = clog2(N);
    localparam int unsigned SW = clog2(T + 1);
    localparam int unsigned RW = clog2(HOLD);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [SW-1:0] step_q, step_d;
    logic [IW-1:0] img_q, img_d;
    logic [RW-1:0] rest_q, rest_d;
    logic [M-1:0]  ips_q, ips_d;
    logic          vb_q, vb_d;
    logic          nxt_q, nxt_d;
    logic          done_q, done_d;

    // Strobes consumed by the spike-count datapath.
    logic          tu_take;     // TU_incre accepted in WAIT_TU
    logic          img_clr;     // counters restart (start, abort, next image)
    logic          rest_enter;  // last timestep of an image accepted

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        step_d     = step_q;
        img_d      = img_q;
        rest_d     = rest_q;
        ips_d      = ips_q;
        vb_d       = 1'b0;
        nxt_d      = 1'b0;
        done_d     = done_q;
        tu_take    = 1'b0;
        img_clr    = 1'b0;
        rest_enter = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            step_d  = '0;
            img_d   = '0;
            rest_d  = '0;
            ips_d   = '0;
            done_d  = 1'b0;
            img_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_FETCH;
                        addr_d  = '0;
                        step_d  = '0;
                        img_d   = '0;
                        done_d  = 1'b0;
                        img_clr = 1'b1;
                    end
                end
                // Address has been stable for a cycle; RAM data is valid next.
                ST_FETCH: state_d = ST_ISSUE;
                ST_ISSUE: begin
                    ips_d   = bus.frame_data;
                    vb_d    = 1'b1;
                    nxt_d   = (step_q == '0) && (img_q != '0);
                    addr_d  = addr_q + AW'(1);
                    step_d  = step_q + SW'(1);
                    state_d = ST_WAIT_TU;
                end
                ST_WAIT_TU: begin
                    if (bus.TU_incre) begin
                        tu_take = 1'b1;
                        if (step_q == SW'(T)) begin
                            state_d    = ST_REST;
                            rest_d     = '0;
                            rest_enter = 1'b1;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_REST: begin
                    if (rest_q == RW'(HOLD - 1)) begin
                        rest_d = '0;
                        if (img_q == IW'(NUM_IMG - 1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            // frame_addr keeps running into the next image.
                            img_d   = img_q + IW'(1);
                            step_d  = '0;
                            img_clr = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        rest_d = rest_q + RW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            step_q  <= '0;
            img_q   <= '0;
            rest_q  <= '0;
            ips_q   <= '0;
            vb_q    <= 1'b0;
            nxt_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            step_q  <= step_d;
            img_q   <= img_d;
            rest_q  <= rest_d;
            ips_q   <= ips_d;
            vb_q    <= vb_d;
            nxt_q   <= nxt_d;
            done_q  <= done_d;
        end
    end

`ifdef SNN_SEQ_SPIKE_COUNT_EN
    logic [N-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NW-1:0]        arg_idx;
    logic [NW-1:0]        winner_q, winner_d;
    logic                 wv_q;

    always_comb begin
        cnt_d = cnt_q;
        if (img_clr) begin
            cnt_d = '0;
        end else if (tu_take) begin
            for (int i = 0; i < N; i++) begin
                if (bus.ops[i] && (cnt_q[i] != {CW{1'b1}})) begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Argmax looks at next-state counts so the final timestep's spikes count.
    spike_argmax #(.N(N), .CW(CW)) u_spike_argmax (
        .cnt_i (cnt_d),
        .idx_o (arg_idx)
    );

    always_comb begin
        winner_d = winner_q;
        if (rest_enter) begin
            winner_d = arg_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            winner_q <= '0;
            wv_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
            wv_q     <= rest_enter;
        end
    end

    assign winner       = winner_q;
    assign winner_valid = wv_q;
`else
    logic unused_cnt;
    assign unused_cnt   = ^{tu_take, img_clr, rest_enter, bus.ops};
    assign winner       = '0;
    assign winner_valid = 1'b0;
`endif

    assign bus.frame_addr  = addr_q;
    assign bus.ips         = ips_q;
    assign bus.valid_board = vb_q;
    assign bus.nxt_img     = nxt_q;
    assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign hold            = (state_q == ST_REST);
    assign done            = done_q;
    assign img_idx         = img_q;
endmodule

// File: tb/tb_snn_img_sequencer.sv
// Directed bench for snn_img_sequencer: T=4, HOLD=3, NUM_IMG=2, CW=2.
// Core model answers TU_incre 5 cycles after every valid_board.
// Winner expectations collapse to 0 when SNN_SEQ_SPIKE_COUNT_EN is not defined.
module tb_snn_img_sequencer;
    localparam int unsigned M = 16, N = 8, T = 4, HOLD = 3, NUM_IMG = 2, AW = 16, CW = 2;
`ifdef SNN_SEQ_SPIKE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, start, abort;
    logic busy, hold, done, winner_valid;
    logic [0:0] img_idx;
    logic [2:0] winner;

    snn_img_sequencer_if #(.M(M), .N(N), .AW(AW)) bus ();

    snn_img_sequencer #(.M(M), .N(N), .T(T), .HOLD(HOLD), .NUM_IMG(NUM_IMG), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bus(bus),
        .busy(busy), .hold(hold), .done(done), .img_idx(img_idx),
        .winner(winner), .winner_valid(winner_valid)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, cyc = 0;
    int run_vb = 0, run_nxt = 0, run_wv = 0;
    int st_cyc = 0, last_vb_cyc = 0, cd = 0, hold_len = 0, idx = 0;
    logic [7:0] ops_tab [16];
    int wexp [2];
    logic core_tu = 1'b0, spur_tu = 1'b0;
    logic [7:0] core_ops = '0, core_ops_pend = '0;
    logic [7:0] spur_ops = 8'h01;
    logic [M-1:0] ram_q;

    function automatic logic [M-1:0] ram_word(input logic [AW-1:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    function automatic int wx(input int w);
        return CNT_EN ? w : 0;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    // Synchronous RAM: data for the address seen at an edge appears after it.
    always @(posedge clk) ram_q <= ram_word(bus.frame_addr);
    assign bus.frame_data = ram_q;
    assign bus.TU_incre   = core_tu | spur_tu;
    assign bus.ops        = core_tu ? core_ops : spur_ops;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor + core model, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        core_tu = 1'b0;
        if (!rst_n) begin
            hold_len = 0;
            cd = 0;
        end else begin
            if (start) begin
                run_vb = 0; run_nxt = 0; run_wv = 0; st_cyc = cyc;
            end
            if (bus.nxt_img) run_nxt++;
            if (bus.valid_board) begin
                idx = run_vb;
                run_vb++;
                check_eq("frame_addr", bus.frame_addr, idx + 1);
                check_eq("ips", bus.ips, ram_word(AW'(idx)));
                check_eq("nxt_img", bus.nxt_img, idx == T);
                if (idx == 0) check_eq("start_lat", cyc - st_cyc, 3);
                else check_eq("vb_gap", cyc - last_vb_cyc, (idx == T) ? 11 : 8);
                last_vb_cyc = cyc;
                core_ops_pend = (idx < 16) ? ops_tab[idx] : 8'h00;
                cd = 5;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    core_tu = 1'b1;
                    core_ops = core_ops_pend;
                end
            end
            if (winner_valid) begin
                check_eq("wv_hold", hold, 1);
                check_eq("wv_lat", cyc - last_vb_cyc, 6);
                check_eq("winner", winner, (run_wv < 2) ? wexp[run_wv] : 99);
                run_wv++;
            end
            if (hold) hold_len++;
            else if (hold_len != 0) begin
                check_eq("hold_len", hold_len, HOLD);
                hold_len = 0;
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic spur(input int c, input int n);
        wait_cyc(c);
        spur_tu = 1'b1;
        wait_cyc(c + n);
        spur_tu = 1'b0;
    endtask

    task automatic load_run(input logic [63:0] pk, input int w0, input int w1);
        for (int i = 0; i < 16; i++) ops_tab[i] = (i < 8) ? pk[8*i +: 8] : 8'h00;
        wexp[0] = wx(w0);
        wexp[1] = wx(w1);
    endtask

    task automatic do_start(output int s);
        start = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        start = 1'b0;
        check_eq("busy_run", busy, 1);
        check_eq("done_clr", done, 0);
    endtask

    task automatic end_checks(input int wfinal);
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("done", done, 1);
        check_eq("busy_done", busy, 0);
        check_eq("hold_done", hold, 0);
        check_eq("addr_end", bus.frame_addr, 8);
        check_eq("img_idx_end", img_idx, 1);
        check_eq("vb_count", run_vb, 8);
        check_eq("nxt_count", run_nxt, 1);
        check_eq("wv_count", run_wv, CNT_EN ? 2 : 0);
        check_eq("winner_end", winner, wx(wfinal));
    endtask

    task automatic check_zero(input string tag, input int wexp_now);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_hold"}, hold, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_vb"}, bus.valid_board, 0);
        check_eq({tag, "_nxt"}, bus.nxt_img, 0);
        check_eq({tag, "_addr"}, bus.frame_addr, 0);
        check_eq({tag, "_ips"}, bus.ips, 0);
        check_eq({tag, "_img"}, img_idx, 0);
        check_eq({tag, "_winner"}, winner, wexp_now);
        check_eq({tag, "_wv"}, winner_valid, 0);
    endtask

    initial begin
        int s;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst", 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Run A: winner 2 in image 0, tie n1/n5 in image 1; spurious TU in FETCH/ISSUE/REST.
        load_run(64'h02_22_22_20_04_04_04_04, 2, 1);
        do_start(s);
        spur(s, 2);
        spur(s + 8, 2);
        spur(s + 16, 2);
        spur(s + 33, 1);
        end_checks(1);

        // Run B from DONE: saturation at CW=2 (n0 4 spikes vs n1 3; n5 4 vs n1 3).
        load_run(64'h20_22_22_22_01_03_03_03, 0, 1);
        do_start(s);
        end_checks(1);

        // Run C: abort together with start and the core's TU_incre in WAIT_TU.
        load_run(64'h00_00_00_00_00_80_80_80, 0, 0);
        do_start(s);
        wait_cyc(s + 23);
        abort = 1'b1;
        start = 1'b1;
        wait_cyc(s + 24);
        abort = 1'b0;
        start = 1'b0;
        check_zero("abort", wx(1));

        // Run C': fresh counters after abort; image 1 all-zero gives winner 0.
        load_run(64'h00_00_00_00_00_80_08_08, 3, 0);
        do_start(s);
        end_checks(0);

        // Run D: reset asserted in the middle of the first REST.
        load_run(64'h00_00_00_00_40_40_40_40, 6, 0);
        do_start(s);
        wait_cyc(s + 33);
        rst_n = 1'b0;
        #1;
        check_zero("rst_rest", 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Run D': normal run after reset release.
        load_run(64'h04_04_04_04_10_10_10_10, 4, 2);
        do_start(s);
        end_checks(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=%0d exp=%0d", cyc, 0);
        $fatal(1, "watchdog");
    end
endmodule
